// File: rtl/hist_builder_mc.sv
// hist_builder_mc: multi-channel dToF histogram builder. Clears bin memory, accumulates
// TDC events over a programmed number of laser cycles, then streams and read-clears the bins.
module hist_builder_mc #(
  parameter int BIN_W = 6,
  parameter int CNT_W = 8,
  parameter int CH_W  = 2,
  parameter int ACQ_W = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic [ACQ_W-1:0]     cfg_acq_num,
  input  logic                 cycle_end,
  input  logic                 ts_valid,
  input  logic [CH_W-1:0]      ts_ch,
  input  logic [BIN_W-1:0]     ts_bin,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [CH_W-1:0]      rd_ch,
  output logic [BIN_W-1:0]     rd_bin,
  output logic [CNT_W-1:0]     rd_count,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<CH_W)-1:0] sat_flags,
  output logic [7:0]           drop_cnt
);

  // state   | meaning
  // IDLE    | waiting for start
  // CLEAR   | zeroing one memory word per cycle
  // ACCUM   | counting events, counting laser cycles
  // DRAIN   | letting the read-modify-write pipeline empty
  // READOUT | streaming words out, clearing each one on transfer

  localparam int AW = CH_W + BIN_W;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_READOUT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] mem_q;
  logic             mem_we, mem_re;
  logic [AW-1:0]    mem_waddr, mem_raddr;
  logic [CNT_W-1:0] mem_wdata;

  logic [ACQ_W-1:0] acq_target, acq_cnt;
  logic             acq_last;
  logic [AW-1:0]    clr_addr;
  logic [AW-1:0]    rd_addr;

  logic             s1_valid, s2_valid;
  logic [AW-1:0]    s1_addr, s2_addr;
  logic [CNT_W-1:0] s2_data;
  logic [CNT_W-1:0] old_val, inc_val;
  logic             hit_sat;

  logic             acc_en, rd_fire, rd_last;

  assign acq_last = (acq_cnt == acq_target - ACQ_W'(1));

  // The word written at the previous edge is not yet visible in mem_q; take it from stage 2.
  assign old_val = (s2_valid && (s2_addr == s1_addr)) ? s2_data : mem_q;
  assign hit_sat = (old_val == CNT_MAX);
  assign inc_val = hit_sat ? old_val : old_val + CNT_W'(1);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CLEAR;
      S_CLEAR:   if (clr_addr == LAST_ADDR) state_nxt = S_ACCUM;
      S_ACCUM:   if (cycle_end && acq_last) state_nxt = S_DRAIN;
      S_DRAIN:   if (!s1_valid) state_nxt = S_READOUT;
      S_READOUT: if (rd_last) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    acc_en  = (state == S_ACCUM) && ts_valid;
    rd_fire = rd_valid && rd_ready;
    rd_last = rd_fire && (rd_addr == LAST_ADDR);

    mem_re    = 1'b0;
    mem_raddr = '0;
    if (acc_en) begin
      mem_re    = 1'b1;
      mem_raddr = {ts_ch, ts_bin};
    end else if ((state == S_DRAIN) && !s1_valid) begin
      mem_re    = 1'b1;
      mem_raddr = '0;
    end else if (rd_fire && !rd_last) begin
      mem_re    = 1'b1;
      mem_raddr = rd_addr + AW'(1);
    end

    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
    end else if (s1_valid) begin
      mem_we    = 1'b1;
      mem_waddr = s1_addr;
      mem_wdata = inc_val;
    end else if (rd_fire) begin
      mem_we    = 1'b1;
      mem_waddr = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_q <= mem[mem_raddr];
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      acq_target <= '0;
      acq_cnt    <= '0;
      clr_addr   <= '0;
      rd_addr    <= '0;
      rd_valid   <= 1'b0;
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s2_valid   <= 1'b0;
      s2_addr    <= '0;
      s2_data    <= '0;
      sat_flags  <= '0;
      drop_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      s1_valid <= acc_en;
      s1_addr  <= {ts_ch, ts_bin};
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_data  <= inc_val;
      done     <= rd_last;

      if ((state == S_IDLE) && start) begin
        acq_target <= (cfg_acq_num == '0) ? ACQ_W'(1) : cfg_acq_num;
        sat_flags  <= '0;
        drop_cnt   <= '0;
        clr_addr   <= '0;
      end else begin
        if (ts_valid && (state != S_ACCUM) && (drop_cnt != 8'hFF))
          drop_cnt <= drop_cnt + 8'd1;
        if (s1_valid && hit_sat)
          sat_flags[s1_addr[AW-1:BIN_W]] <= 1'b1;
      end

      if (state == S_CLEAR)
        clr_addr <= clr_addr + AW'(1);

      if (state == S_CLEAR)
        acq_cnt <= '0;
      else if ((state == S_ACCUM) && cycle_end && !acq_last)
        acq_cnt <= acq_cnt + ACQ_W'(1);

      if ((state == S_DRAIN) && !s1_valid) begin
        rd_valid <= 1'b1;
        rd_addr  <= '0;
      end else if (rd_fire) begin
        if (rd_last)
          rd_valid <= 1'b0;
        else
          rd_addr <= rd_addr + AW'(1);
      end
    end
  end

  assign rd_ch    = rd_addr[AW-1:BIN_W];
  assign rd_bin   = rd_addr[BIN_W-1:0];
  assign rd_count = rd_valid ? mem_q : '0;

endmodule

// File: tb/tb_hist_builder_mc.sv
// Bench for hist_builder_mc: reference histogram model feeds an expected-beat queue,
// a negedge monitor pops and compares every transferred readout beat.
module tb_hist_builder_mc;
  localparam int BIN_W = 6;
  localparam int CNT_W = 8;
  localparam int CH_W  = 2;
  localparam int ACQ_W = 16;
  localparam int NCH   = 4;
  localparam int NBIN  = 64;

  logic             clk = 1'b0;
  logic             res, start, cycle_end, ts_valid, rd_ready;
  logic [ACQ_W-1:0] cfg_acq_num;
  logic [CH_W-1:0]  ts_ch, rd_ch;
  logic [BIN_W-1:0] ts_bin, rd_bin;
  logic [CNT_W-1:0] rd_count;
  logic             rd_valid, busy, done;
  logic [NCH-1:0]   sat_flags;
  logic [7:0]       drop_cnt;

  hist_builder_mc #(.BIN_W(BIN_W), .CNT_W(CNT_W), .CH_W(CH_W), .ACQ_W(ACQ_W)) dut (
    .clk(clk), .res(res), .start(start), .cfg_acq_num(cfg_acq_num),
    .cycle_end(cycle_end), .ts_valid(ts_valid), .ts_ch(ts_ch), .ts_bin(ts_bin),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ch(rd_ch), .rd_bin(rd_bin),
    .rd_count(rd_count), .busy(busy), .done(done), .sat_flags(sat_flags),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [1:0] ch;
    logic [5:0] bin;
    logic       ce;
  } stim_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ce_cyc = 0;
  int first_valid_cyc = -1;
  int done_pulses = 0;
  int beat_idx = 0;
  int ready_mode = 0;

  logic [15:0]    exp_q[$];
  stim_t          stim_q[$];
  int             hist[NCH][NBIN];
  logic [NCH-1:0] m_sat;
  int             m_drops;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // rd_ready driver: 0 = always ready, 1 = repeating 1,0,0,1, otherwise random
  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pi = 0;
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) rd_ready = 1'b1;
      else if (ready_mode == 1) begin
        rd_ready = pat[pi];
        pi = (pi + 1) % 4;
      end else rd_ready = 1'($urandom);
    end
  end

  logic        stall_prev = 1'b0;
  logic [16:0] prev_word;
  logic [15:0] mon_e;

  always @(negedge clk) begin
    if (res) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if ({rd_valid, rd_ch, rd_bin, rd_count} !== prev_word) begin
          n_err++;
          $display("FAIL hold_stable: got v=%0d ch=%0d bin=%0d cnt=%0d expected v=1 ch=%0d bin=%0d cnt=%0d",
                   rd_valid, rd_ch, rd_bin, rd_count, prev_word[15:14], prev_word[13:8], prev_word[7:0]);
        end
      end
      if (rd_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got ch=%0d bin=%0d cnt=%0d expected no beat", rd_ch, rd_bin, rd_count);
        end else begin
          mon_e = exp_q.pop_front();
          if ({rd_ch, rd_bin, rd_count} !== mon_e) begin
            n_err++;
            $display("FAIL beat[%0d]: got ch=%0d bin=%0d cnt=%0d expected ch=%0d bin=%0d cnt=%0d",
                     beat_idx, rd_ch, rd_bin, rd_count, mon_e[15:14], mon_e[13:8], mon_e[7:0]);
          end
          beat_idx++;
        end
      end
      stall_prev = rd_valid && !rd_ready;
      prev_word  = {rd_valid, rd_ch, rd_bin, rd_count};
      if (done === 1'b1) done_pulses++;
    end
  end

  task automatic model_reset();
    foreach (hist[c, b]) hist[c][b] = 0;
    m_sat   = '0;
    m_drops = 0;
  endtask

  task automatic model_drop();
    if (m_drops < 255) m_drops++;
  endtask

  task automatic model_hit(input int c, input int b);
    if (hist[c][b] == 255) m_sat[c] = 1'b1;
    else hist[c][b]++;
  endtask

  task automatic push_expected();
    logic [15:0] w;
    first_valid_cyc = -1;
    ce_cyc = cyc;
    beat_idx = 0;
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < NBIN; b++) begin
        w = {2'(c), 6'(b), 8'(hist[c][b])};
        exp_q.push_back(w);
      end
  endtask

  task automatic add(input logic v, input logic [1:0] ch, input logic [5:0] bin, input logic ce);
    stim_t e;
    e.v = v; e.ch = ch; e.bin = bin; e.ce = ce;
    stim_q.push_back(e);
  endtask

  task automatic gen_random(input int n, input int tgt);
    logic ce;
    stim_q.delete();
    for (int i = 0; i < n; i++) begin
      ce = 1'b0;
      for (int j = 1; j <= tgt; j++) if (i == (j * n) / tgt - 1) ce = 1'b1;
      add($urandom_range(3) != 0, 2'($urandom),
          ($urandom_range(1) != 0) ? 6'($urandom_range(3)) : 6'($urandom), ce);
    end
    add(1'b1, 2'($urandom), 6'($urandom), 1'b0);
    add(1'b1, 2'($urandom), 6'($urandom), 1'b0);
  endtask

  // start, then walk the 256 CLEAR cycles; an event on the last CLEAR cycle must be dropped
  task automatic do_start(input int acq);
    int busy_bad = 0;
    model_reset();
    ts_valid = 1'b0;
    cycle_end = 1'b0;
    start = 1'b1;
    cfg_acq_num = ACQ_W'(acq);
    tick();
    start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
    end
    if (busy !== 1'b1) busy_bad++;
    ts_valid = 1'b1;
    ts_ch = 2'($urandom);
    ts_bin = 6'($urandom);
    model_drop();
    tick();
    ts_valid = 1'b0;
    chk("busy_during_clear", busy_bad, 0);
  endtask

  task automatic run_stim(input int tgt);
    int   ces = 0;
    logic in_acc = 1'b1;
    foreach (stim_q[k]) begin
      ts_valid  = stim_q[k].v;
      ts_ch     = stim_q[k].ch;
      ts_bin    = stim_q[k].bin;
      cycle_end = stim_q[k].ce;
      if (stim_q[k].v) begin
        if (in_acc) model_hit(stim_q[k].ch, stim_q[k].bin);
        else model_drop();
      end
      if (stim_q[k].ce && in_acc) begin
        ces++;
        if (ces == tgt) begin
          in_acc = 1'b0;
          push_expected();
        end
      end
      tick();
    end
    ts_valid = 1'b0;
    cycle_end = 1'b0;
  endtask

  task automatic finish_acq(input logic noise);
    logic got = 1'b0;
    logic busy_at_done = 1'b1;
    int   pulses0 = done_pulses;
    for (int c = 0; c < 3000; c++) begin
      if (noise) begin
        ts_valid = 1'($urandom);
        ts_ch = 2'($urandom);
        ts_bin = 6'($urandom);
        if (ts_valid) model_drop();
      end
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        busy_at_done = busy;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    ts_valid = 1'b0;
    chk("done_seen", got, 1);
    if (!got) begin
      exp_q.delete();
      return;
    end
    chk("busy_with_done", busy_at_done, 0);
    chk("done_single_cycle", done, 0);
    chk("beats_left", exp_q.size(), 0);
    chk("first_beat_latency_ok", (first_valid_cyc - ce_cyc) inside {[1:5]}, 1);
    chk("sat_flags", sat_flags, m_sat);
    chk("drop_cnt", drop_cnt, m_drops);
    chk("done_pulses", done_pulses - pulses0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_ch"}, rd_ch, 0);
    chk({tag, "_rd_bin"}, rd_bin, 0);
    chk({tag, "_rd_count"}, rd_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sat_flags"}, sat_flags, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acq, tgt;
    res = 1'b1; start = 1'b0; cfg_acq_num = '0; cycle_end = 1'b0;
    ts_valid = 1'b0; ts_ch = '0; ts_bin = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    res = 1'b0;
    tick();

    // single event (1,5) -> only beat 69 is 1
    ready_mode = 0;
    stim_q.delete();
    add(1'b1, 2'd1, 6'd5, 1'b0);
    add(1'b0, 2'd0, 6'd0, 1'b1);
    do_start(1); run_stim(1); finish_acq(1'b0);

    // back-to-back same-address events across two laser cycles
    ready_mode = 2;
    stim_q.delete();
    add(1'b1, 2'd2, 6'd63, 1'b0);
    add(1'b1, 2'd2, 6'd63, 1'b0);
    add(1'b1, 2'd2, 6'd63, 1'b1);
    add(1'b1, 2'd2, 6'd63, 1'b0);
    add(1'b1, 2'd2, 6'd63, 1'b0);
    add(1'b1, 2'd0, 6'd0, 1'b0);
    add(1'b1, 2'd0, 6'd0, 1'b0);
    add(1'b1, 2'd0, 6'd0, 1'b1);
    add(1'b1, 2'd1, 6'd7, 1'b0);
    do_start(2); run_stim(2); finish_acq(1'b1);

    // saturation, with cfg_acq_num=0 meaning one laser cycle
    ready_mode = 0;
    stim_q.delete();
    for (int i = 0; i < 299; i++) add(1'b1, 2'd3, 6'd10, 1'b0);
    add(1'b1, 2'd3, 6'd10, 1'b1);
    do_start(0); run_stim(1); finish_acq(1'b0);

    // stalled readout with ready pattern 1,0,0,1
    ready_mode = 1;
    gen_random(60, 3);
    do_start(3); run_stim(3); finish_acq(1'b1);

    // empty acquisition reads all zeros
    ready_mode = 0;
    stim_q.delete();
    add(1'b0, 2'd0, 6'd0, 1'b1);
    do_start(1); run_stim(1); finish_acq(1'b0);

    for (int r = 0; r < 3; r++) begin
      ready_mode = 2;
      acq = $urandom_range(4);
      tgt = (acq == 0) ? 1 : acq;
      gen_random(40 + 20 * r, tgt);
      do_start(acq); run_stim(tgt); finish_acq(1'b1);
    end

    // idle drops, then abort mid-ACCUM, then a clean acquisition
    res = 1'b1; tick(); res = 1'b0; tick();
    model_reset();
    for (int i = 0; i < 10; i++) begin
      ts_valid = 1'b1;
      ts_ch = 2'($urandom);
      ts_bin = 6'($urandom);
      model_drop();
      tick();
    end
    ts_valid = 1'b0;
    chk("drop_cnt_idle", drop_cnt, m_drops);
    do_start(3);
    for (int i = 0; i < 6; i++) begin
      ts_valid = 1'b1;
      ts_ch = 2'd3;
      ts_bin = 6'(i);
      tick();
    end
    chk("drop_before_res", drop_cnt, m_drops);
    ts_valid = 1'b0;
    res = 1'b1;
    #1;
    chk_all_zero("abort");
    tick();
    res = 1'b0;
    tick();
    chk("busy_after_abort", busy, 0);
    ready_mode = 2;
    stim_q.delete();
    add(1'b1, 2'd3, 6'd1, 1'b0);
    add(1'b1, 2'd3, 6'd1, 1'b0);
    add(1'b1, 2'd3, 6'd2, 1'b1);
    do_start(1); run_stim(1); finish_acq(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
